// File: rtl/vault_pkg.sv
// Shared definitions for the vault lock controller: the 3-bit state encoding.
package vault_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_CHECK   = 3'd1,
    ST_OPEN    = 3'd2,
    ST_LOCKOUT = 3'd3,
    ST_PROGRAM = 3'd4
  } state_e;

endpackage

// File: rtl/vault_timer.sv
// Loadable down-counter that stops at zero; shared by the lockout and auto-relock intervals.
module vault_timer #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         RESETN,
  input  logic         load,
  input  logic [W-1:0] value,
  output logic         zero
);

  logic [W-1:0] cnt_d, cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = value;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!RESETN) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero = (cnt_q == '0);

endmodule

// File: rtl/vault_lock_ctrl.sv
// Keypad vault lock: collects digit entries, checks against a programmable code,
// enforces a lockout after repeated failures and relocks automatically after a timeout.
module vault_lock_ctrl
  import vault_pkg::*;
#(
  parameter int                              DIGIT_W        = 4,
  parameter int                              NUM_DIGITS     = 4,
  parameter logic [NUM_DIGITS*DIGIT_W-1:0]   DEFAULT_CODE   = 16'h1234,
  parameter int                              MAX_TRIES      = 3,
  parameter int                              LOCKOUT_CYCLES = 1000,
  parameter int                              UNLOCK_CYCLES  = 5000
) (
  input  logic                               clk,
  input  logic                               RESETN,
  input  logic                               ENTER,
  input  logic [DIGIT_W-1:0]                 DIGIT,
  input  logic                               CLEAR,
  input  logic                               LOCK_REQ,
  input  logic                               SET_EN,
  output logic                               UNLOCKED,
  output logic                               ERROR,
  output logic                               LOCKED_OUT,
  output logic [$clog2(MAX_TRIES+1)-1:0]     TRIES_LEFT,
  output logic [$clog2(NUM_DIGITS+1)-1:0]    DIGIT_COUNT,
  output logic [2:0]                         STATE
);

  localparam int CODE_W  = NUM_DIGITS * DIGIT_W;
  localparam int CNT_W   = $clog2(NUM_DIGITS + 1);
  localparam int TRY_W   = $clog2(MAX_TRIES + 1);
  localparam int TMR_MAX = (LOCKOUT_CYCLES > UNLOCK_CYCLES) ? LOCKOUT_CYCLES : UNLOCK_CYCLES;
  localparam int TMR_W   = (TMR_MAX > 1) ? $clog2(TMR_MAX) : 1;

  state_e              state_d, state_q;
  logic [CODE_W-1:0]   entry_d, entry_q;
  logic [CODE_W-1:0]   code_d, code_q;
  logic [CNT_W-1:0]    cnt_d, cnt_q;
  logic [TRY_W-1:0]    tries_d, tries_q;
  logic                error_d, error_q;
  logic                enter_d, enter_q;

  logic                edge_det;
  logic                last_digit;
  logic [CODE_W-1:0]   shifted;
  logic                tmr_load;
  logic [TMR_W-1:0]    tmr_val;
  logic                tmr_zero;

  vault_timer #(.W(TMR_W)) u_timer (
    .clk    (clk),
    .RESETN (RESETN),
    .load   (tmr_load),
    .value  (tmr_val),
    .zero   (tmr_zero)
  );

  assign edge_det   = ENTER & ~enter_q;
  assign last_digit = (cnt_q == CNT_W'(NUM_DIGITS - 1));
  assign shifted    = (entry_q << DIGIT_W) | CODE_W'(DIGIT);

  always_comb begin
    state_d  = state_q;
    entry_d  = entry_q;
    code_d   = code_q;
    cnt_d    = cnt_q;
    tries_d  = tries_q;
    error_d  = 1'b0;
    enter_d  = ENTER;
    tmr_load = 1'b0;
    tmr_val  = TMR_W'(UNLOCK_CYCLES - 1);

    case (state_q)
      ST_IDLE: begin
        if (CLEAR) begin
          entry_d = '0;
          cnt_d   = '0;
        end else if (edge_det) begin
          entry_d = shifted;
          if (last_digit) begin
            cnt_d   = '0;
            state_d = ST_CHECK;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end

      ST_CHECK: begin
        // Timer is loaded for whichever timed state follows; a reload on the IDLE path is harmless.
        tmr_load = 1'b1;
        entry_d  = '0;
        if (entry_q == code_q) begin
          state_d = ST_OPEN;
          tries_d = TRY_W'(MAX_TRIES);
        end else begin
          error_d = 1'b1;
          tries_d = tries_q - TRY_W'(1);
          if (tries_q == TRY_W'(1)) begin
            state_d = ST_LOCKOUT;
            tmr_val = TMR_W'(LOCKOUT_CYCLES - 1);
          end else begin
            state_d = ST_IDLE;
          end
        end
      end

      ST_OPEN: begin
        if (LOCK_REQ || tmr_zero) begin
          state_d = ST_IDLE;
        end else if (edge_det) begin
          tmr_load = 1'b1;
          if (SET_EN) begin
            state_d = ST_PROGRAM;
          end
        end
      end

      ST_LOCKOUT: begin
        if (tmr_zero) begin
          state_d = ST_IDLE;
          tries_d = TRY_W'(MAX_TRIES);
          entry_d = '0;
          cnt_d   = '0;
        end
      end

      ST_PROGRAM: begin
        if (LOCK_REQ) begin
          state_d = ST_IDLE;
          entry_d = '0;
          cnt_d   = '0;
        end else if (CLEAR) begin
          entry_d = '0;
          cnt_d   = '0;
        end else if (edge_det) begin
          if (last_digit) begin
            code_d  = shifted;
            entry_d = '0;
            cnt_d   = '0;
            state_d = ST_IDLE;
          end else begin
            entry_d = shifted;
            cnt_d   = cnt_q + CNT_W'(1);
          end
        end
      end

      default: begin
        state_d = ST_IDLE;
        entry_d = '0;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!RESETN) begin
      state_q <= ST_IDLE;
      entry_q <= '0;
      code_q  <= DEFAULT_CODE;
      cnt_q   <= '0;
      tries_q <= TRY_W'(MAX_TRIES);
      error_q <= 1'b0;
      enter_q <= 1'b0;
    end else begin
      state_q <= state_d;
      entry_q <= entry_d;
      code_q  <= code_d;
      cnt_q   <= cnt_d;
      tries_q <= tries_d;
      error_q <= error_d;
      enter_q <= enter_d;
    end
  end

  assign UNLOCKED    = (state_q == ST_OPEN);
  assign LOCKED_OUT  = (state_q == ST_LOCKOUT);
  assign ERROR       = error_q;
  assign TRIES_LEFT  = tries_q;
  assign DIGIT_COUNT = cnt_q;
  assign STATE       = state_q;

endmodule

// File: tb/tb_vault_lock_ctrl.sv
// Bench for vault_lock_ctrl: vector table, directed corner sequences, and random traffic
// compared against a queue-based behavioural model.
module tb_vault_lock_ctrl;
  import vault_pkg::*;

  localparam int NUM  = 4;
  localparam int MAXT = 3;
  localparam int LOCK = 8;
  localparam int UNLK = 16;

  localparam int M_IDLE = 0, M_CHECK = 1, M_OPEN = 2, M_LOCK = 3, M_PROG = 4;

  logic       clk = 1'b0;
  logic       resetn, enter, clear, lock_req, set_en;
  logic [3:0] digit;
  logic       unlocked, error, locked_out;
  logic [1:0] tries_left;
  logic [2:0] digit_count;
  logic [2:0] state;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  vault_lock_ctrl #(
    .DIGIT_W        (4),
    .NUM_DIGITS     (NUM),
    .DEFAULT_CODE   (16'h1234),
    .MAX_TRIES      (MAXT),
    .LOCKOUT_CYCLES (LOCK),
    .UNLOCK_CYCLES  (UNLK)
  ) dut (
    .clk         (clk),
    .RESETN      (resetn),
    .ENTER       (enter),
    .DIGIT       (digit),
    .CLEAR       (clear),
    .LOCK_REQ    (lock_req),
    .SET_EN      (set_en),
    .UNLOCKED    (unlocked),
    .ERROR       (error),
    .LOCKED_OUT  (locked_out),
    .TRIES_LEFT  (tries_left),
    .DIGIT_COUNT (digit_count),
    .STATE       (state)
  );

  // Behavioural model: digits kept as queues, timed states as remaining-cycle counts.
  int m_mode;
  int q[$];
  int attempt[$];
  int m_code[$];
  int m_tries;
  int m_left;
  bit m_err;
  bit m_prev;

  function automatic bit codes_match();
    if (attempt.size() != m_code.size()) return 1'b0;
    foreach (attempt[i]) if (attempt[i] != m_code[i]) return 1'b0;
    return 1'b1;
  endfunction

  function automatic void model_step(bit e, int d, bit c, bit l, bit s, bit r);
    bit ed;
    int dd;
    dd = d & 15;
    if (!r) begin
      m_mode  = M_IDLE;
      q.delete();
      attempt.delete();
      m_code  = '{1, 2, 3, 4};
      m_tries = MAXT;
      m_left  = 0;
      m_err   = 1'b0;
      m_prev  = 1'b0;
      return;
    end
    ed     = e && !m_prev;
    m_prev = e;
    m_err  = 1'b0;
    case (m_mode)
      M_IDLE: begin
        if (c) q.delete();
        else if (ed) begin
          q.push_back(dd);
          if (q.size() == NUM) begin
            attempt = q;
            q.delete();
            m_mode = M_CHECK;
          end
        end
      end
      M_CHECK: begin
        if (codes_match()) begin
          m_mode  = M_OPEN;
          m_tries = MAXT;
          m_left  = UNLK;
        end else begin
          m_err   = 1'b1;
          m_tries = m_tries - 1;
          if (m_tries == 0) begin
            m_mode = M_LOCK;
            m_left = LOCK;
          end else begin
            m_mode = M_IDLE;
          end
        end
      end
      M_OPEN: begin
        if (l || m_left == 1) m_mode = M_IDLE;
        else if (ed && s) m_mode = M_PROG;
        else if (ed) m_left = UNLK;
        else m_left = m_left - 1;
      end
      M_LOCK: begin
        if (m_left == 1) begin
          m_mode  = M_IDLE;
          m_tries = MAXT;
        end else begin
          m_left = m_left - 1;
        end
      end
      default: begin
        if (l) begin
          q.delete();
          m_mode = M_IDLE;
        end else if (c) q.delete();
        else if (ed) begin
          q.push_back(dd);
          if (q.size() == NUM) begin
            m_code = q;
            q.delete();
            m_mode = M_IDLE;
          end
        end
      end
    endcase
  endfunction

  function automatic logic [2:0] mode_state(int m);
    case (m)
      M_CHECK: return ST_CHECK;
      M_OPEN:  return ST_OPEN;
      M_LOCK:  return ST_LOCKOUT;
      M_PROG:  return ST_PROGRAM;
      default: return ST_IDLE;
    endcase
  endfunction

  task automatic check(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick(bit e, int d, bit c, bit l, bit s, bit r);
    @(negedge clk);
    enter    = e;
    digit    = 4'(d);
    clear    = c;
    lock_req = l;
    set_en   = s;
    resetn   = r;
    @(posedge clk);
    #1;
    model_step(e, d, c, l, s, r);
  endtask

  task automatic enter_digit(int d);
    tick(1'b1, d, 1'b0, 1'b0, 1'b0, 1'b1);
    tick(1'b0, d, 1'b0, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic enter_code(int a, int b, int c, int d);
    enter_digit(a);
    enter_digit(b);
    enter_digit(c);
    enter_digit(d);
  endtask

  task automatic idle_tick();
    tick(1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic check_model(string tag);
    check({tag, "_unlocked"},   unlocked,    m_mode == M_OPEN);
    check({tag, "_locked_out"}, locked_out,  m_mode == M_LOCK);
    check({tag, "_error"},      error,       m_err);
    check({tag, "_tries"},      tries_left,  m_tries);
    check({tag, "_count"},      digit_count, q.size());
    check({tag, "_state"},      state,       mode_state(m_mode));
  endtask

  typedef struct {
    bit e; int d; bit c; bit l; bit s; bit r;
    bit unl; bit err; bit lo; int tries; int cnt; logic [2:0] st;
  } vec_t;

  function automatic vec_t mk(bit e, int d, bit c, bit l, bit r, bit unl, int cnt, logic [2:0] st);
    vec_t v;
    v.e = e; v.d = d; v.c = c; v.l = l; v.s = 1'b0; v.r = r;
    v.unl = unl; v.err = 1'b0; v.lo = 1'b0; v.tries = MAXT; v.cnt = cnt; v.st = st;
    return v;
  endfunction

  vec_t tbl[18];

  initial begin
    enter = 0; digit = 0; clear = 0; lock_req = 0; set_en = 0; resetn = 0;

    //           e  d  c  l  r  unl cnt state
    tbl[0]  = mk(0, 0, 0, 0, 0, 0,  0,  ST_IDLE);
    tbl[1]  = mk(1, 1, 0, 0, 1, 0,  1,  ST_IDLE);
    tbl[2]  = mk(0, 1, 0, 0, 1, 0,  1,  ST_IDLE);
    tbl[3]  = mk(1, 2, 0, 0, 1, 0,  2,  ST_IDLE);
    tbl[4]  = mk(0, 2, 0, 0, 1, 0,  2,  ST_IDLE);
    tbl[5]  = mk(1, 9, 1, 0, 1, 0,  0,  ST_IDLE);
    tbl[6]  = mk(0, 9, 0, 0, 1, 0,  0,  ST_IDLE);
    tbl[7]  = mk(1, 1, 0, 0, 1, 0,  1,  ST_IDLE);
    tbl[8]  = mk(1, 1, 0, 0, 1, 0,  1,  ST_IDLE);
    tbl[9]  = mk(1, 5, 0, 0, 1, 0,  1,  ST_IDLE);
    tbl[10] = mk(0, 0, 0, 0, 1, 0,  1,  ST_IDLE);
    tbl[11] = mk(1, 2, 0, 0, 1, 0,  2,  ST_IDLE);
    tbl[12] = mk(0, 0, 0, 0, 1, 0,  2,  ST_IDLE);
    tbl[13] = mk(1, 3, 0, 0, 1, 0,  3,  ST_IDLE);
    tbl[14] = mk(0, 0, 0, 0, 1, 0,  3,  ST_IDLE);
    tbl[15] = mk(1, 4, 0, 0, 1, 0,  0,  ST_CHECK);
    tbl[16] = mk(0, 0, 0, 0, 1, 1,  0,  ST_OPEN);
    tbl[17] = mk(0, 0, 0, 1, 1, 0,  0,  ST_IDLE);

    tick(0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 18; i++) begin
      tick(tbl[i].e, tbl[i].d, tbl[i].c, tbl[i].l, tbl[i].s, tbl[i].r);
      check($sformatf("vec%0d_unlocked", i),   unlocked,    tbl[i].unl);
      check($sformatf("vec%0d_error", i),      error,       tbl[i].err);
      check($sformatf("vec%0d_locked_out", i), locked_out,  tbl[i].lo);
      check($sformatf("vec%0d_tries", i),      tries_left,  tbl[i].tries);
      check($sformatf("vec%0d_count", i),      digit_count, tbl[i].cnt);
      check($sformatf("vec%0d_state", i),      state,       tbl[i].st);
    end

    // Unlock latency and auto-relock after UNLK cycles
    enter_digit(1); enter_digit(2); enter_digit(3);
    tick(1, 4, 0, 0, 0, 1);
    check("unlock_check_state", state, ST_CHECK);
    check("unlock_not_yet", unlocked, 0);
    idle_tick();
    check("unlock_two_cycles", unlocked, 1);
    check("unlock_tries", tries_left, MAXT);
    repeat (UNLK - 1) idle_tick();
    check("open_before_timeout", unlocked, 1);
    idle_tick();
    check("relock_unlocked", unlocked, 0);
    check("relock_state", state, ST_IDLE);

    // ENTER edge in OPEN restarts the relock timer
    enter_code(1, 2, 3, 4);
    repeat (10) idle_tick();
    tick(1, 0, 0, 0, 0, 1);
    repeat (UNLK - 1) idle_tick();
    check("reload_still_open", unlocked, 1);
    idle_tick();
    check("reload_then_relock", state, ST_IDLE);

    // LOCK_REQ beats a same-cycle SET_EN edge
    enter_code(1, 2, 3, 4);
    tick(1, 0, 0, 1, 1, 1);
    check("lockreq_over_set", state, ST_IDLE);
    idle_tick();

    // Three wrong codes -> lockout, ENTER ignored, then recovery
    for (int k = 1; k <= 3; k++) begin
      enter_code(1, 2, 3, 5);
      check($sformatf("wrong%0d_error", k), error, 1);
      check($sformatf("wrong%0d_tries", k), tries_left, MAXT - k);
      check($sformatf("wrong%0d_locked", k), locked_out, k == 3);
      if (k < 3) begin
        idle_tick();
        check($sformatf("wrong%0d_pulse_end", k), error, 0);
      end
    end
    for (int i = 0; i < LOCK - 1; i++) begin
      tick((i % 2) == 0, 1, 0, 0, 0, 1);
      check($sformatf("lockout%0d_locked", i), locked_out, 1);
      check($sformatf("lockout%0d_count", i), digit_count, 0);
    end
    idle_tick();
    check("lockout_exit_locked", locked_out, 0);
    check("lockout_exit_tries", tries_left, MAXT);
    check("lockout_exit_state", state, ST_IDLE);

    // Program new code 9876
    enter_code(1, 2, 3, 4);
    tick(1, 9, 0, 0, 1, 1);
    check("prog_state", state, ST_PROGRAM);
    check("prog_unlocked", unlocked, 0);
    check("prog_count", digit_count, 0);
    idle_tick();
    enter_digit(9); enter_digit(8); enter_digit(7);
    tick(1, 6, 0, 0, 0, 1);
    check("prog_done_state", state, ST_IDLE);
    idle_tick();
    enter_code(1, 2, 3, 4);
    check("old_code_error", error, 1);
    check("old_code_tries", tries_left, 2);
    enter_code(9, 8, 7, 6);
    check("new_code_unlocked", unlocked, 1);
    check("new_code_tries", tries_left, MAXT);
    tick(0, 0, 0, 1, 0, 1);

    // Reset mid-entry restores the default code
    enter_digit(1); enter_digit(2); enter_digit(3);
    tick(0, 0, 0, 0, 0, 0);
    check("rst_unlocked", unlocked, 0);
    check("rst_error", error, 0);
    check("rst_locked", locked_out, 0);
    check("rst_tries", tries_left, MAXT);
    check("rst_count", digit_count, 0);
    check("rst_state", state, ST_IDLE);
    enter_code(1, 2, 3, 4);
    check("rst_default_code", unlocked, 1);
    tick(0, 0, 0, 1, 0, 1);

    // Reset mid-program leaves no partial code behind
    enter_code(1, 2, 3, 4);
    tick(1, 0, 0, 0, 1, 1);
    idle_tick();
    enter_digit(5); enter_digit(6);
    tick(0, 0, 0, 0, 0, 0);
    enter_code(1, 2, 3, 4);
    check("rst_prog_code_kept", unlocked, 1);
    tick(0, 0, 0, 1, 0, 1);

    // Random traffic against the model
    for (int n = 0; n < 3000; n++) begin
      int d;
      bit e, c, l, s, r;
      d = $urandom_range(0, 15);
      if (m_mode == M_IDLE && q.size() < NUM && $urandom_range(0, 3) != 0) d = m_code[q.size()];
      e = $urandom_range(0, 1);
      c = ($urandom_range(0, 29) == 0);
      l = ($urandom_range(0, 19) == 0);
      s = ($urandom_range(0, 3) == 0);
      r = ($urandom_range(0, 199) != 0);
      tick(e, d, c, l, s, r);
      check_model($sformatf("rnd%0d", n));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/vault_lock_ctrl.md
VAULT_LOCK_CTRL -- requirements
Module: vault_lock_ctrl

Interface
REQ-001 Parameter DIGIT_W, 4, bits per entered digit.
REQ-002 Parameter NUM_DIGITS, 4, digits per code (>=1).
REQ-003 Parameter DEFAULT_CODE, 16'h1234, code after reset (NUM_DIGITS*DIGIT_W bits; first-entered digit in MS nibble).
REQ-004 Parameter MAX_TRIES, 3, consecutive failures allowed before lockout (>=1).
REQ-005 Parameter LOCKOUT_CYCLES, 1000, lockout duration in clk cycles (>=1).
REQ-006 Parameter UNLOCK_CYCLES, 5000, auto-relock timeout in clk cycles (>=1).
REQ-007 clk  in  1  clock; all logic on rising edge.
REQ-008 RESETN  in  1  reset, synchronous, active-low.
REQ-009 ENTER  in  1  level; its rising edge submits DIGIT.
REQ-010 DIGIT  in  DIGIT_W  digit value, sampled on the ENTER rising-edge cycle.
REQ-011 CLEAR  in  1  discards partial entry.
REQ-012 LOCK_REQ  in  1  relocks from OPEN.
REQ-013 SET_EN  in  1  qualifies ENTER in OPEN to start code programming.
REQ-014 UNLOCKED  out  1  high in OPEN only.
REQ-015 ERROR  out  1  one-cycle pulse per wrong code.
REQ-016 LOCKED_OUT  out  1  high in LOCKOUT only.
REQ-017 TRIES_LEFT  out  $clog2(MAX_TRIES+1)  remaining attempts.
REQ-018 DIGIT_COUNT  out  $clog2(NUM_DIGITS+1)  digits collected in current entry.
REQ-019 STATE  out  3  current state encoding (package enum).

Function
REQ-020 Edge: ENTER registered once; edge = ENTER & ~ENTER_q; a held ENTER yields exactly one edge.
REQ-021 States: IDLE, CHECK, OPEN, LOCKOUT, PROGRAM; all outputs registered or decoded from state registers only.
REQ-022 IDLE/PROGRAM: each edge shifts DIGIT into the entry buffer and increments DIGIT_COUNT.
REQ-023 CLEAR in IDLE/PROGRAM zeroes buffer and DIGIT_COUNT; CLEAR wins over a same-cycle edge (digit dropped).
REQ-024 IDLE: the edge completing NUM_DIGITS digits moves to CHECK next cycle; DIGIT_COUNT returns to 0.
REQ-025 CHECK (one cycle): buffer==code -> OPEN, TRIES_LEFT reloads MAX_TRIES; mismatch -> ERROR pulses, TRIES_LEFT decrements.
REQ-026 Mismatch with TRIES_LEFT==1 -> LOCKOUT, timer loads LOCKOUT_CYCLES-1; otherwise -> IDLE.
REQ-027 UNLOCKED asserts two cycles after the sampling edge of the final digit's ENTER edge.
REQ-028 LOCKOUT: ENTER, CLEAR, DIGIT ignored; timer decrements per cycle; at 0 -> IDLE, TRIES_LEFT reloads MAX_TRIES, buffer cleared.
REQ-029 OPEN: timer loads UNLOCK_CYCLES-1 on entry and reloads on every ENTER edge; at 0 or LOCK_REQ -> IDLE.
REQ-030 OPEN: edge with SET_EN=1 -> PROGRAM (digit not captured); LOCK_REQ wins over same-cycle SET_EN edge.
REQ-031 PROGRAM: completing NUM_DIGITS digits writes buffer to code register and -> IDLE; UNLOCKED low throughout.
REQ-032 PROGRAM: LOCK_REQ aborts to IDLE; code unchanged.
REQ-033 DIGIT values are unrestricted (full DIGIT_W range valid).

Reset
REQ-034 RESETN low at a clk edge: state IDLE, code DEFAULT_CODE, buffer 0, DIGIT_COUNT 0, TRIES_LEFT MAX_TRIES, timer 0, ENTER_q 0, UNLOCKED 0, ERROR 0, LOCKED_OUT 0.
REQ-035 Reset mid-entry, mid-lockout, or mid-program overrides every other input; no partial programmed code survives.

Structure
REQ-036 Package vault_pkg holds the state enum (3-bit) and STATE encodings; parameters stay on the module.
REQ-037 One sub-module vault_timer: loadable down-counter, width $clog2(max(LOCKOUT_CYCLES,UNLOCK_CYCLES)), ports load, value, zero, shared by LOCKOUT and OPEN.

Verification (DEFAULT_CODE=16'h1234, MAX_TRIES=3, LOCKOUT_CYCLES=8, UNLOCK_CYCLES=16)
REQ-038 Enter 1,2,3,4 -> UNLOCKED=1 two cycles after final edge, TRIES_LEFT=3; hold 16 idle cycles -> UNLOCKED=0, STATE=IDLE.
REQ-039 Enter 1,2,3,5 three times -> ERROR pulses thrice, TRIES_LEFT 2,1,then LOCKED_OUT=1; 8 cycles later -> IDLE, TRIES_LEFT=3; ENTER during lockout leaves DIGIT_COUNT=0.
REQ-040 Enter 1,2 then CLEAR coincident with ENTER edge of 9 -> DIGIT_COUNT=0; then 1,2,3,4 -> OPEN.
REQ-041 Unlock, SET_EN edge, enter 9,8,7,6 -> IDLE; 1,2,3,4 -> ERROR; 9,8,7,6 -> UNLOCKED=1.
REQ-042 Enter 1,2,3 then RESETN low one cycle -> all outputs at reset values; code remains 16'h1234.
REQ-043 ENTER held high 10 cycles with DIGIT=1 -> DIGIT_COUNT=1 only.
